// File: rtl/dict_pkg.sv
// Shared types for the Stage-1 dictionary compressor sequencer.
// Contents: token-kind enum, comparator match-type encodings, controller FSM states,
// and a helper saying which token kinds allocate a new dictionary entry.
package dict_pkg;

    typedef enum logic [2:0] {
        KIND_ZERO   = 3'd0,
        KIND_FULL   = 3'd1,
        KIND_PART24 = 3'd2,
        KIND_PART16 = 3'd3,
        KIND_MISS   = 3'd4
    } kind_t;

    // Comparator o_type_matched encodings
    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_UP16 = 2'b01;
    localparam logic [1:0] CMP_UP24 = 2'b10;
    localparam logic [1:0] CMP_FULL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_OUT
    } state_t;

    // Only tokens carrying a residual add the word to the dictionary
    function automatic logic kind_writes(input kind_t kind);
        return (kind == KIND_MISS) || (kind == KIND_PART16) || (kind == KIND_PART24);
    endfunction

endpackage

// File: rtl/dict_regfile.sv
// Dictionary storage with FIFO replacement.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (zeroes data, valid, pointer, fill)
//   clear      synchronous clear of valid bits, pointer and fill (data words kept)
//   wr_en      write wr_data at the write pointer, mark it valid, advance the pointer
//   wr_data    word to store
//   dict_flat  all entries, entry k at bits [k*WIDTH +: WIDTH]
//   valid      per-entry valid bits
//   fill       number of valid entries, saturating at ENTRIES
module dict_regfile #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH*ENTRIES-1:0]   dict_flat,
    output logic [ENTRIES-1:0]         valid,
    output logic [IDX_W:0]             fill
);

    logic [WIDTH-1:0] entry [ENTRIES];
    logic [IDX_W-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                entry[k] <= '0;
            end
            valid  <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            valid  <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (wr_en) begin
            entry[wr_ptr] <= wr_data;
            valid[wr_ptr] <= 1'b1;
            // ENTRIES is a power of two, so the pointer wraps on its own
            wr_ptr        <= wr_ptr + IDX_W'(1);
            if (fill != (IDX_W+1)'(ENTRIES)) begin
                fill <= fill + (IDX_W+1)'(1);
            end
        end
    end

    for (genvar k = 0; k < ENTRIES; k++) begin : g_flat
        assign dict_flat[k*WIDTH +: WIDTH] = entry[k];
    end

endmodule

// File: rtl/dict_match_ctrl.sv
// Sequencer for the Stage-1 dictionary compressor.
// Accepts a word (i_valid/o_ready), presents it with the dictionary to the external
// combinational comparator, classifies the result into a token (o_valid/i_ready) and,
// on token acceptance, adds residual-bearing words to the dictionary.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_clear                 dictionary clear, honoured only when idle
//   i_valid, o_ready, i_word  input word handshake
//   o_cmp_input, o_cmp_dict to comparator; i_cmp_type, i_cmp_loc from comparator
//   o_valid, i_ready        token handshake; o_kind, o_index, o_literal token fields
//   o_fill                  number of valid dictionary entries
module dict_match_ctrl
    import dict_pkg::*;
#(
    parameter int INPUT_WORD = 32,
    parameter int DICT_ENTRY = 16,
    parameter int IDX_W      = $clog2(DICT_ENTRY)
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_clear,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [INPUT_WORD-1:0]            i_word,
    output logic [INPUT_WORD-1:0]            o_cmp_input,
    output logic [INPUT_WORD*DICT_ENTRY-1:0] o_cmp_dict,
    input  logic [1:0]                       i_cmp_type,
    input  logic [IDX_W-1:0]                 i_cmp_loc,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [2:0]                       o_kind,
    output logic [IDX_W-1:0]                 o_index,
    output logic [INPUT_WORD-1:0]            o_literal,
    output logic [IDX_W:0]                   o_fill
);

    state_t                 state, state_next;
    kind_t                  kind, kind_next, cls_kind;
    logic [INPUT_WORD-1:0]  cmp_input_next, literal_next, cls_literal;
    logic [IDX_W-1:0]       index_next, cls_index;
    logic                   valid_next;
    logic                   dict_clear, dict_we;
    logic [DICT_ENTRY-1:0]  dict_valid;

    assign o_kind = kind;

    dict_regfile #(
        .WIDTH   (INPUT_WORD),
        .ENTRIES (DICT_ENTRY),
        .IDX_W   (IDX_W)
    ) u_regfile (
        .clk       (i_clk),
        .rst       (i_reset),
        .clear     (dict_clear),
        .wr_en     (dict_we),
        .wr_data   (o_cmp_input),
        .dict_flat (o_cmp_dict),
        .valid     (dict_valid),
        .fill      (o_fill)
    );

    // Classifier: zero word wins, then a hit on an invalid entry is a miss
    always_comb begin
        cls_kind    = KIND_MISS;
        cls_index   = '0;
        cls_literal = o_cmp_input;
        if (o_cmp_input == '0) begin
            cls_kind    = KIND_ZERO;
            cls_literal = '0;
        end else if (dict_valid[i_cmp_loc]) begin
            unique case (i_cmp_type)
                CMP_FULL: begin
                    cls_kind    = KIND_FULL;
                    cls_index   = i_cmp_loc;
                    cls_literal = '0;
                end
                CMP_UP24: begin
                    cls_kind         = KIND_PART24;
                    cls_index        = i_cmp_loc;
                    cls_literal      = '0;
                    cls_literal[7:0] = o_cmp_input[7:0];
                end
                CMP_UP16: begin
                    cls_kind          = KIND_PART16;
                    cls_index         = i_cmp_loc;
                    cls_literal       = '0;
                    cls_literal[15:0] = o_cmp_input[15:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        cmp_input_next = o_cmp_input;
        valid_next     = o_valid;
        kind_next      = kind;
        index_next     = o_index;
        literal_next   = o_literal;
        o_ready        = 1'b0;
        dict_clear     = 1'b0;
        dict_we        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_clear) begin
                    dict_clear = 1'b1;
                end else begin
                    o_ready = !i_reset;
                    if (i_valid) begin
                        cmp_input_next = i_word;
                        state_next     = S_CMP;
                    end
                end
            end
            S_CMP: begin
                kind_next    = cls_kind;
                index_next   = cls_index;
                literal_next = cls_literal;
                valid_next   = 1'b1;
                state_next   = S_OUT;
            end
            S_OUT: begin
                if (i_ready) begin
                    dict_we    = kind_writes(kind);
                    valid_next = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            o_cmp_input <= '0;
            o_valid     <= 1'b0;
            kind        <= KIND_ZERO;
            o_index     <= '0;
            o_literal   <= '0;
        end else begin
            state       <= state_next;
            o_cmp_input <= cmp_input_next;
            o_valid     <= valid_next;
            kind        <= kind_next;
            o_index     <= index_next;
            o_literal   <= literal_next;
        end
    end

endmodule

// File: tb/tb_dict_match_ctrl.sv
// Self-checking bench for dict_match_ctrl: directed table, multi-cycle corner
// sequences and randomized words against a behavioural dictionary model.
module tb_dict_match_ctrl;

    localparam logic [2:0] K_ZERO = 3'd0, K_FULL = 3'd1, K_P24 = 3'd2, K_P16 = 3'd3, K_MISS = 3'd4;

    logic         clk, i_reset, i_clear, i_valid, o_ready, o_valid, i_ready;
    logic [31:0]  i_word, o_cmp_input, o_literal;
    logic [511:0] o_cmp_dict;
    logic [1:0]   i_cmp_type;
    logic [3:0]   i_cmp_loc, o_index;
    logic [2:0]   o_kind;
    logic [4:0]   o_fill;

    dict_match_ctrl dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_word      (i_word),
        .o_cmp_input (o_cmp_input),
        .o_cmp_dict  (o_cmp_dict),
        .i_cmp_type  (i_cmp_type),
        .i_cmp_loc   (i_cmp_loc),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_kind      (o_kind),
        .o_index     (o_index),
        .o_literal   (o_literal),
        .o_fill      (o_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural dictionary model
    logic [31:0] mdict [16];
    logic        mvalid [16];
    int          mptr, mfill;
    logic [31:0] last_word;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  ctype;
        logic [3:0]  cloc;
        int          hold;
        bit          clr;
        logic [2:0]  kind;
        logic [3:0]  idx;
        logic [31:0] lit;
        logic [4:0]  fill;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_dict(input string name);
        logic [511:0] exp;
        for (int k = 0; k < 16; k++) exp[k*32 +: 32] = mdict[k];
        tests++;
        if (o_cmp_dict !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, o_cmp_dict, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) begin
            mdict[k]  = '0;
            mvalid[k] = 1'b0;
        end
        mptr      = 0;
        mfill     = 0;
        last_word = '0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 16; k++) mvalid[k] = 1'b0;
        mptr  = 0;
        mfill = 0;
    endfunction

    function automatic void model_accept(input logic [31:0] w, input logic [2:0] k);
        if (k == K_MISS || k == K_P16 || k == K_P24) begin
            mdict[mptr]  = w;
            mvalid[mptr] = 1'b1;
            mptr         = (mptr + 1) % 16;
            if (mfill < 16) mfill++;
        end
    endfunction

    // Comparator stand-in: longest upper-bit match over raw entry data, lowest index first
    function automatic void cmp_model(input logic [31:0] w, output logic [1:0] t,
                                      output logic [3:0] l);
        t = 2'b00;
        l = '0;
        for (int lvl = 3; lvl >= 1; lvl--) begin
            for (int k = 15; k >= 0; k--) begin
                if ((lvl == 3 && mdict[k] == w) ||
                    (lvl == 2 && mdict[k][31:8] == w[31:8]) ||
                    (lvl == 1 && mdict[k][31:16] == w[31:16])) begin
                    t = 2'(lvl);
                    l = 4'(k);
                end
            end
            if (t != 2'b00) return;
        end
    endfunction

    function automatic void expect_tok(input logic [31:0] w, input logic [1:0] t,
                                       input logic [3:0] l, output logic [2:0] k,
                                       output logic [3:0] idx, output logic [31:0] lit);
        idx = l;
        if (w == 0) begin
            k = K_ZERO; idx = 0; lit = 0;
        end else if (!mvalid[l] || t == 2'b00) begin
            k = K_MISS; idx = 0; lit = w;
        end else if (t == 2'b11) begin
            k = K_FULL; lit = 0;
        end else if (t == 2'b10) begin
            k = K_P24; lit = w & 32'h0000_00ff;
        end else begin
            k = K_P16; lit = w & 32'h0000_ffff;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_word = '0; i_cmp_type = '0; i_cmp_loc = '0;
        #1;
        model_reset();
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_fill", o_fill, 0);
        chk("rst_kind", o_kind, 0);
        chk("rst_index", o_index, 0);
        chk("rst_literal", o_literal, 0);
        chk("rst_cmp_input", o_cmp_input, 0);
        chk_dict("rst_dict");
        @(negedge clk);
        i_reset = 1'b0;
        #1 chk("rst_release_ready", o_ready, 1);
    endtask

    // One word through the full handshake, with hold cycles of i_ready=0 in S_OUT
    task automatic apply_tok(input logic [31:0] w, input logic [1:0] t, input logic [3:0] l,
                             input logic [2:0] ek, input logic [3:0] ei, input logic [31:0] el,
                             input int hold, input bit clr);
        int n;
        @(negedge clk);
        i_word = w; i_cmp_type = t; i_cmp_loc = l; i_valid = 1'b1; i_ready = (hold == 0);
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            tests++; fails++;
            $display("FAIL ready_timeout: got o_ready=0 expected 1 within 20 cycles");
            i_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        last_word = w;
        chk("lat_cmp_valid", o_valid, 0);
        chk("cmp_input", o_cmp_input, w);
        @(posedge clk); #1;
        chk("lat_out_valid", o_valid, 1);
        chk("kind", o_kind, ek);
        chk("index", o_index, ei);
        chk("literal", o_literal, el);
        chk("out_ready", o_ready, 0);
        for (int h = 0; h < hold; h++) begin
            i_clear = clr;
            i_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", o_valid, 1);
            chk("hold_kind", o_kind, ek);
            chk("hold_index", o_index, ei);
            chk("hold_literal", o_literal, el);
            chk("hold_ready", o_ready, 0);
            chk("hold_fill", o_fill, mfill);
            chk_dict("hold_dict");
        end
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        model_accept(w, ek);
        chk("accept_valid", o_valid, 0);
        chk("accept_fill", o_fill, mfill);
        chk_dict("accept_dict");
        i_ready = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1; i_valid = 1'b1; i_word = $urandom | 32'h1;
        #1 chk("clear_ready", o_ready, 0);
        @(posedge clk); #1;
        model_clear();
        chk("clear_fill", o_fill, 0);
        chk("clear_no_accept_valid", o_valid, 0);
        chk("clear_no_accept_input", o_cmp_input, last_word);
        chk_dict("clear_dict_kept");
        @(negedge clk);
        i_clear = 1'b0; i_valid = 1'b0;
    endtask

    logic [31:0] w, w0;
    logic [1:0]  t;
    logic [3:0]  l, ei;
    logic [2:0]  ek;
    logic [31:0] el;

    initial begin
        i_reset = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_word = '0; i_cmp_type = '0; i_cmp_loc = '0;
        tbl[0] = '{32'h12345678, 2'b00, 4'd0, 0, 1'b0, K_MISS, 4'd0, 32'h12345678, 5'd1};
        tbl[1] = '{32'h12345678, 2'b11, 4'd0, 0, 1'b0, K_FULL, 4'd0, 32'h0, 5'd1};
        tbl[2] = '{32'h1234ABCD, 2'b01, 4'd0, 5, 1'b1, K_P16, 4'd0, 32'h0000ABCD, 5'd2};
        tbl[3] = '{32'h00000000, 2'b11, 4'd2, 0, 1'b0, K_ZERO, 4'd0, 32'h0, 5'd2};
        tbl[4] = '{32'h12345699, 2'b10, 4'd0, 1, 1'b0, K_P24, 4'd0, 32'h00000099, 5'd3};
        tbl[5] = '{32'h55550000, 2'b11, 4'd9, 0, 1'b0, K_MISS, 4'd0, 32'h55550000, 5'd4};

        // Directed table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_tok(tbl[i].word, tbl[i].ctype, tbl[i].cloc, tbl[i].kind, tbl[i].idx,
                      tbl[i].lit, tbl[i].hold, tbl[i].clr);
            chk("tbl_fill", o_fill, tbl[i].fill);
        end
        chk("tbl_entry0", o_cmp_dict[31:0], 32'h12345678);
        chk("tbl_entry1", o_cmp_dict[63:32], 32'h1234ABCD);
        chk("tbl_entry2", o_cmp_dict[95:64], 32'h12345699);

        // Pointer wrap: 17 distinct misses
        do_reset();
        for (int i = 0; i < 17; i++) begin
            w = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
            cmp_model(w, t, l);
            expect_tok(w, t, l, ek, ei, el);
            apply_tok(w, t, l, ek, ei, el, 0, 1'b0);
        end
        chk("wrap_entry0", o_cmp_dict[31:0], 32'h1010_0010);
        chk("wrap_fill", o_fill, 16);
        w0 = 32'h1000_0000;
        cmp_model(w0, t, l);
        apply_tok(w0, t, l, K_MISS, 4'd0, w0, 0, 1'b0);
        chk("wrap_entry1", o_cmp_dict[63:32], w0);
        chk("wrap_fill_sat", o_fill, 16);

        // Clear after three inserts, then a stale entry must not match
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w = 32'hC0DE_0000 + 32'(i) * 32'h0101_0101;
            cmp_model(w, t, l);
            expect_tok(w, t, l, ek, ei, el);
            apply_tok(w, t, l, ek, ei, el, 0, 1'b0);
        end
        chk("pre_clear_fill", o_fill, 3);
        do_clear();
        w = 32'hC1DF_0101;
        cmp_model(w, t, l);
        chk("stale_cmp_type", t, 2'b11);
        apply_tok(w, t, l, K_MISS, 4'd0, w, 0, 1'b0);

        // Asynchronous reset while a token waits in S_OUT
        @(negedge clk);
        i_word = 32'hDEAD_BEEF; i_cmp_type = 2'b00; i_cmp_loc = '0; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1 i_valid = 1'b0;
        @(posedge clk); #1 chk("pre_reset_valid", o_valid, 1);
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        model_reset();
        chk("async_valid", o_valid, 0);
        chk("async_fill", o_fill, 0);
        chk("async_ready", o_ready, 0);
        chk_dict("async_dict");
        @(negedge clk);
        i_reset = 1'b0;
        #1 chk("async_release_ready", o_ready, 1);

        // Randomized words against the model
        for (int i = 0; i < 120; i++) begin
            int k;
            k = $urandom_range(0, 15);
            case ($urandom_range(0, 5))
                0: w = '0;
                1: w = mdict[k];
                2: w = {mdict[k][31:8], 8'($urandom)};
                3: w = {mdict[k][31:16], 16'($urandom)};
                default: w = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                t = 2'($urandom);
                l = 4'($urandom);
            end else begin
                cmp_model(w, t, l);
            end
            expect_tok(w, t, l, ek, ei, el);
            apply_tok(w, t, l, ek, ei, el, $urandom_range(0, 2), 1'($urandom));
            if ($urandom_range(0, 14) == 0) do_clear();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
